// File: rtl/cpc_rom_loader_if.sv
// Bus bundle between mist_io (download stream) and the SDRAM write port.
// The loader uses the master view; the OSD/SDRAM side uses the slave view.
interface cpc_rom_loader_if #(
    parameter int PAGE_BITS = 8,
    parameter int BANKS     = 2
);
    localparam int ADDR_W = PAGE_BITS + 15;
    localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;

    logic                ioctl_download;
    logic                ioctl_wr;
    logic [24:0]         ioctl_addr;
    logic [7:0]          ioctl_dout;
    logic [7:0]          ioctl_index;
    logic [15:0]         ioctl_file_ext;
    logic                model;
    logic                ioctl_wait;

    logic                mem_req;
    logic                mem_ack;
    logic [ADDR_W-1:0]   mem_addr;
    logic [BANK_W-1:0]   mem_bank;
    logic [7:0]          mem_dout;

    modport master (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        input  ioctl_index, ioctl_file_ext, model, mem_ack,
        output ioctl_wait, mem_req, mem_addr, mem_bank, mem_dout
    );

    modport slave (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        output ioctl_index, ioctl_file_ext, model, mem_ack,
        input  ioctl_wait, mem_req, mem_addr, mem_bank, mem_dout
    );
endinterface

// File: rtl/cpc_rom_loader.sv
// ROM download loader: decodes the target ROM page from the file extension,
// buffers bytes in a small FIFO towards SDRAM (req/ack) and records which
// upper-ROM pages have been loaded.
module cpc_rom_loader #(
    parameter int PAGE_BITS  = 8,
    parameter int BANKS      = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = PAGE_BITS + 15
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    cpc_rom_loader_if.master     bus,
    input  logic [PAGE_BITS-1:0] map_addr,
    output logic                 map_hit,
    input  logic                 map_clear,
    output logic                 busy,
    output logic                 load_err
);
    localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int ENT_W  = ADDR_W + BANK_W + 8;
    localparam int NPAGES = 1 << PAGE_BITS;

    localparam logic [1:0] MODE_SYS   = 2'd0;
    localparam logic [1:0] MODE_EXP   = 2'd1;
    localparam logic [1:0] MODE_COMBO = 2'd2;
    localparam logic [1:0] MODE_DROP  = 2'd3;

    // Returns {valid, nibble} for an upper-case ASCII hex digit.
    function automatic logic [4:0] hex_nib(input logic [7:0] c);
        logic [4:0] r;
        if ((c >= 8'h30) && (c <= 8'h39)) begin
            r = {1'b1, c[3:0]};
        end else if ((c >= 8'h41) && (c <= 8'h46)) begin
            r = {1'b1, c[3:0] + 4'd9};
        end else begin
            r = 5'b0_0000;
        end
        return r;
    endfunction

    logic [1:0]            mode_q, mode_d;
    logic [PAGE_BITS-1:0]  base_q, base_d;
    logic                  region_q, region_d;
    logic [BANK_W-1:0]     bsel_q, bsel_d;
    logic                  dl_q, dl_d;
    logic                  err_q, err_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic                  req_q, req_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [BANK_W-1:0]     bank_q, bank_d;
    logic [7:0]            dout_q, dout_d;
    logic                  wait_q, wait_d;
    logic                  busy_q, busy_d;
    logic [NPAGES-1:0]     map_q, map_d;
    logic                  hit_q, hit_d;
    logic [ENT_W-1:0]      fifo_mem_q [FIFO_DEPTH];

    logic                  rise_s;
    logic [4:0]            hi_s, lo_s;
    logic [1:0]            dec_mode_s;
    logic [PAGE_BITS-1:0]  dec_base_s;
    logic                  dec_region_s;
    logic [10:0]           blk_s;
    logic [PAGE_BITS-1:0]  blk_pg_s;
    logic                  disc_s;
    logic                  ent_region_s;
    logic [PAGE_BITS-1:0]  ent_page_s;
    logic [BANK_W-1:0]     ent_bank_s;
    logic [ENT_W-1:0]      push_ent_s;
    logic [ENT_W-1:0]      head_s;
    logic                  push_req_s, push_s, pop_s, full_s, ovf_s;

    // Download-start detection and mode latch; the start cycle itself already uses the new mode.
    always_comb begin
        rise_s       = bus.ioctl_download & ~dl_q;
        dl_d         = bus.ioctl_download;
        hi_s         = hex_nib(bus.ioctl_file_ext[15:8]);
        lo_s         = hex_nib(bus.ioctl_file_ext[7:0]);
        dec_mode_s   = MODE_DROP;
        dec_base_s   = '0;
        dec_region_s = 1'b0;
        if (bus.ioctl_index == 8'd0) begin
            dec_mode_s = MODE_SYS;
        end else if (hi_s[4] & lo_s[4]) begin
            dec_mode_s   = MODE_EXP;
            dec_base_s   = PAGE_BITS'({hi_s[3:0], lo_s[3:0]});
            dec_region_s = 1'b1;
        end else if (bus.ioctl_file_ext == 16'h5A5A) begin
            dec_mode_s = MODE_EXP;
        end else if (bus.ioctl_file_ext == 16'h5A30) begin
            dec_mode_s = MODE_COMBO;
        end else begin
            dec_mode_s = MODE_DROP;
        end
        if (rise_s) begin
            mode_d   = dec_mode_s;
            base_d   = dec_base_s;
            region_d = dec_region_s;
            bsel_d   = BANK_W'(bus.model);
        end else begin
            mode_d   = mode_q;
            base_d   = base_q;
            region_d = region_q;
            bsel_d   = bsel_q;
        end
    end

    // Byte address/bank computation for the incoming byte under the current mode.
    always_comb begin
        blk_s        = bus.ioctl_addr[24:14];
        blk_pg_s     = PAGE_BITS'(blk_s);
        disc_s       = 1'b0;
        ent_region_s = 1'b0;
        ent_page_s   = '0;
        ent_bank_s   = bsel_d;
        case (mode_d)
            MODE_SYS: begin
                disc_s     = |blk_s[10:3];
                ent_bank_s = BANK_W'(blk_s[2]);
                case (blk_s[1:0])
                    2'd0:    begin ent_region_s = 1'b0; ent_page_s = '0; end
                    2'd1:    begin ent_region_s = 1'b1; ent_page_s = '0; end
                    2'd2:    begin ent_region_s = 1'b1; ent_page_s = PAGE_BITS'(3'd7); end
                    default: begin ent_region_s = 1'b1; ent_page_s = '1; end
                endcase
            end
            MODE_EXP: begin
                ent_region_s = region_d;
                ent_page_s   = base_d + blk_pg_s;
            end
            MODE_COMBO: begin
                if (blk_s == 11'd0) begin
                    ent_region_s = 1'b0;
                    ent_page_s   = '0;
                end else if (blk_s == 11'd1) begin
                    ent_region_s = 1'b1;
                    ent_page_s   = '1;
                end else begin
                    disc_s = 1'b1;
                end
            end
            default: begin
                disc_s = 1'b1;
            end
        endcase
        push_ent_s = {ent_region_s, ent_page_s, bus.ioctl_addr[13:0], ent_bank_s, bus.ioctl_dout};
    end

    // FIFO control, presented head entry, status flags and bitmap update.
    always_comb begin
        push_req_s = bus.ioctl_wr & bus.ioctl_download & (mode_d != MODE_DROP) & ~disc_s;
        pop_s      = req_q & bus.mem_ack;
        full_s     = (cnt_q == CNT_W'(FIFO_DEPTH));
        push_s     = push_req_s & (~full_s | pop_s);
        ovf_s      = push_req_s & full_s & ~pop_s;

        if (push_s & ~pop_s) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (pop_s & ~push_s) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
        wr_ptr_d = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;

        // A byte written into the slot about to become the head bypasses the array.
        if (push_s && (wr_ptr_q == rd_ptr_d)) begin
            head_s = push_ent_s;
        end else begin
            head_s = fifo_mem_q[rd_ptr_d];
        end

        req_d = (cnt_d != '0);
        if (req_d) begin
            {addr_d, bank_d, dout_d} = head_s;
        end else begin
            addr_d = addr_q;
            bank_d = bank_q;
            dout_d = dout_q;
        end
        wait_d = (cnt_d >= CNT_W'(FIFO_DEPTH - 1));
        busy_d = bus.ioctl_download | req_d;

        if (rise_s) begin
            err_d = (dec_mode_s == MODE_DROP) | ovf_s;
        end else begin
            err_d = err_q | ovf_s;
        end

        map_d = map_q;
        if (pop_s & addr_q[ADDR_W-1]) begin
            map_d[addr_q[ADDR_W-2 -: PAGE_BITS]] = 1'b1;
        end else begin
            map_d = map_q;
        end
        if (map_clear) begin
            map_d = '0;
        end else begin
            map_d = map_d;
        end
        hit_d = map_q[map_addr];
    end

    // State and output registers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            mode_q   <= MODE_DROP;
            base_q   <= '0;
            region_q <= 1'b0;
            bsel_q   <= '0;
            dl_q     <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            req_q    <= 1'b0;
            addr_q   <= '0;
            bank_q   <= '0;
            dout_q   <= 8'd0;
            wait_q   <= 1'b0;
            busy_q   <= 1'b0;
            map_q    <= '0;
            hit_q    <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            base_q   <= base_d;
            region_q <= region_d;
            bsel_q   <= bsel_d;
            dl_q     <= dl_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            bank_q   <= bank_d;
            dout_q   <= dout_d;
            wait_q   <= wait_d;
            busy_q   <= busy_d;
            map_q    <= map_d;
            hit_q    <= hit_d;
        end
    end

    // FIFO storage array.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
        end else if (push_s) begin
            fifo_mem_q[wr_ptr_q] <= push_ent_s;
        end
    end

    assign bus.mem_req    = req_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_bank   = bank_q;
    assign bus.mem_dout   = dout_q;
    assign bus.ioctl_wait = wait_q;
    assign map_hit        = hit_q;
    assign busy           = busy_q;
    assign load_err       = err_q;
endmodule
